// File: rtl/rom_16x16.sv
// rom_16x16: 16 x 16-bit coefficient ROM with a registered, enabled read port.
// The table lives in mem[0:DEPTH-1] and is loaded at time zero through a
// declaration initialiser, so there is no write port and reset never touches it.
// Only the output register is reset; it holds its value whenever r_en is low.

module rom_16x16 #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              r_en,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] data
);

   typedef logic [DATA_W-1:0] mem_t [0:DEPTH-1];

   // Default table contents; entries beyond the 16 defined words read as zero.
   function automatic logic [DATA_W-1:0] word_at(input int idx);
      case (idx)
         0:       return DATA_W'(16'h0103);
         1:       return DATA_W'(16'h5200);
         2:       return DATA_W'(16'he0b9);
         3:       return DATA_W'(16'h0412);
         4:       return DATA_W'(16'h4839);
         5:       return DATA_W'(16'h0112);
         6:       return DATA_W'(16'h0377);
         7:       return DATA_W'(16'h0572);
         8:       return DATA_W'(16'hcafe);
         9:       return DATA_W'(16'h6225);
         10:      return DATA_W'(16'h1447);
         11:      return DATA_W'(16'haeec);
         12:      return DATA_W'(16'h52dd);
         13:      return DATA_W'(16'h1113);
         14:      return DATA_W'(16'h4444);
         15:      return DATA_W'(16'h5555);
         default: return '0;
      endcase
   endfunction

   function automatic mem_t rom_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = word_at(i);
      end
      return m;
   endfunction

   // Storage is a plain variable (not a net) so a bench can overwrite words
   // hierarchically; the design itself never writes it.
   mem_t mem = rom_init();

   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // Next read word: capture on enable, zero for addresses past the table, else hold.
   always_comb begin
      data_d = data_q;
      if (r_en) begin
         if (int'(addr) < DEPTH) begin
            data_d = mem[addr];
         end else begin
            data_d = '0;
         end
      end
   end

   // Output register; async reset clears it without needing a clock.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q <= '0;
      end else begin
         data_q <= data_d;
      end
   end

   assign data = data_q;

endmodule

// File: tb/tb_rom_16x16.sv
// Bench for rom_16x16: table-driven read vectors plus hand sequences for
// reset, hold, hierarchical rewrite and between-edge address changes.
// Inputs change just after a falling edge; data is checked at the next
// falling edge, half a cycle after the capturing rising edge.

module tb_rom_16x16;

   logic        clk;
   logic        rst_n;
   logic        r_en;
   logic [3:0]  addr;
   logic [15:0] data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] sb_q [$];

   typedef struct {
      logic        en;
      logic [3:0]  a;
      logic [15:0] exp;
      string       nm;
   } vec_t;

   vec_t vecs [$];

   logic [15:0] ref_tab [0:15];

   rom_16x16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .r_en  (r_en),
      .addr  (addr),
      .data  (data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: data=%h expected=%h", nm, act, exp);
      end
   endtask

   // Drive one cycle of stimulus, queue its expected word, then pop and
   // compare once the capturing edge has passed.
   task automatic apply(input logic en, input logic [3:0] a, input logic [15:0] exp,
                        input string nm);
      logic [15:0] e;
      r_en = en;
      addr = a;
      sb_q.push_back(exp);
      @(negedge clk);
      if (sb_q.size() == 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", nm);
      end else begin
         e = sb_q.pop_front();
         check(nm, data, e);
      end
   endtask

   initial begin
      vec_t v;
      ref_tab = '{16'h0103, 16'h5200, 16'he0b9, 16'h0412, 16'h4839, 16'h0112,
                  16'h0377, 16'h0572, 16'hcafe, 16'h6225, 16'h1447, 16'haeec,
                  16'h52dd, 16'h1113, 16'h4444, 16'h5555};

      // Vector table: idle-after-reset, full sweep, then read/hold/read.
      for (int i = 0; i < 3; i++) begin
         v.en = 1'b0; v.a = 4'd3; v.exp = 16'h0000; v.nm = $sformatf("idle%0d", i);
         vecs.push_back(v);
      end
      for (int i = 0; i < 16; i++) begin
         v.en = 1'b1; v.a = 4'(i); v.exp = ref_tab[i]; v.nm = $sformatf("sweep%0d", i);
         vecs.push_back(v);
      end
      v.en = 1'b1; v.a = 4'd11; v.exp = 16'haeec; v.nm = "rd11";   vecs.push_back(v);
      v.en = 1'b0; v.a = 4'd12; v.exp = 16'haeec; v.nm = "hold_a"; vecs.push_back(v);
      v.en = 1'b0; v.a = 4'd12; v.exp = 16'haeec; v.nm = "hold_b"; vecs.push_back(v);
      v.en = 1'b1; v.a = 4'd12; v.exp = 16'h52dd; v.nm = "rd12";   vecs.push_back(v);
      v.en = 1'b1; v.a = 4'd15; v.exp = 16'h5555; v.nm = "rd15";   vecs.push_back(v);
      v.en = 1'b1; v.a = 4'd0;  v.exp = 16'h0103; v.nm = "rd0";    vecs.push_back(v);

      rst_n = 1'b0;
      r_en  = 1'b0;
      addr  = 4'd0;
      @(negedge clk);
      check("reset_init", data, 16'h0000);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         apply(vecs[i].en, vecs[i].a, vecs[i].exp, vecs[i].nm);
      end

      // Hierarchical rewrite is visible to the next read.
      dut.mem[5] = 16'hbeef;
      apply(1'b1, 4'd5, 16'hbeef, "rewrite5");
      apply(1'b1, 4'd4, 16'h4839, "after_rewrite4");

      // Address changes between edges: only the value present at the edge counts.
      r_en = 1'b1;
      addr = 4'd4;
      #2 addr = 4'd9;
      sb_q.push_back(16'h6225);
      @(negedge clk);
      check("midcycle_addr", data, sb_q.pop_front());

      // Enable dropped before the edge after toggling high mid-cycle: nothing captured.
      r_en = 1'b1;
      addr = 4'd2;
      #2 r_en = 1'b0;
      @(negedge clk);
      check("midcycle_en", data, 16'h6225);

      // Asynchronous reset mid-cycle while holding cafe.
      apply(1'b1, 4'd8, 16'hcafe, "rd8");
      r_en = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_reset", data, 16'h0000);
      check("mem8_kept", dut.mem[8], 16'hcafe);
      r_en = 1'b1;
      addr = 4'd8;
      @(negedge clk);
      check("reset_hold", data, 16'h0000);

      // Release with r_en high: first capture on the first edge after release.
      rst_n = 1'b1;
      apply(1'b1, 4'd2, 16'he0b9, "post_reset_rd2");
      apply(1'b1, 4'd8, 16'hcafe, "post_reset_rd8");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
